// File: rtl/spram_lsu_bridge.sv
// LSU-to-spram bridge: byte/half/word requests become word accesses with
// byte masks, and load data comes back aligned and extended.
// Responses go through a small FIFO so the LSU can apply back-pressure.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_valid_i/req_ready_o  LSU request handshake
//   req_addr_i, req_we_i     byte address, 1=store
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           zero-extend loads when 1
//   req_wdata_i              right-justified store data
//   rsp_valid_o/rsp_ready_i  response handshake (FIFO head)
//   rsp_rdata_o, rsp_err_o   extended load data, misaligned/illegal flag
//   mem_*                    spram side (1-cycle read latency)
module spram_lsu_bridge #(
    parameter int ADDRW     = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [ADDRW-1:0] req_addr_i,
    input  logic             req_we_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             mem_valid_o,
    output logic             mem_we_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_mask_o,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_resp_i
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 2);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
        logic       we;
        logic       err;
    } meta_t;

    meta_t          r_meta;
    logic           r_inflight;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [31:0]    r_data [RSP_DEPTH];
    logic           r_err  [RSP_DEPTH];

    logic [1:0]     w_off;
    logic           w_err;
    logic           w_fire;
    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_occ;
    logic [CW-1:0]  w_occ_net;
    logic [31:0]    w_wdata;
    logic [3:0]     w_mask;
    logic [31:0]    w_sh;
    logic [31:0]    w_fmt;

    assign w_off = req_addr_i[1:0];
    assign w_err = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b01) & w_off[0])
                 | ((req_size_i == 2'b10) & (w_off != 2'b00));

    // In-flight request already owns a FIFO slot; a pop this
    // cycle frees one, so ready depends combinationally on rsp_ready_i.
    assign rsp_valid_o = (r_count != '0);
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign w_occ       = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_occ_net   = w_occ - {{(CW-1){1'b0}}, w_pop};
    assign req_ready_o = (w_occ_net < DEPTH_C);
    assign w_fire      = req_valid_i & req_ready_o;

    assign mem_valid_o = w_fire;
    assign mem_we_o    = req_we_i & ~w_err;
    assign mem_addr_o  = {req_addr_i[ADDRW-1:2], 2'b00};

    always_comb begin
        w_wdata = req_wdata_i;
        w_mask  = 4'b1111;
        case (req_size_i)
            2'b00: begin
                w_wdata = {4{req_wdata_i[7:0]}};
                w_mask  = 4'b0001 << w_off;
            end
            2'b01: begin
                w_wdata = {2{req_wdata_i[15:0]}};
                w_mask  = 4'b0011 << w_off;
            end
            default: ;
        endcase
    end

    assign mem_wdata_o = w_wdata;
    assign mem_mask_o  = mem_we_o ? w_mask : 4'b0000;

    assign w_sh   = mem_rdata_i >> {r_meta.off, 3'b000};
    assign w_push = mem_resp_i & r_inflight;

    always_comb begin
        w_fmt = w_sh;
        case (r_meta.size)
            2'b00: w_fmt = {{24{~r_meta.uns & w_sh[7]}}, w_sh[7:0]};
            2'b01: w_fmt = {{16{~r_meta.uns & w_sh[15]}}, w_sh[15:0]};
            default: ;
        endcase
        if (r_meta.we | r_meta.err) begin
            w_fmt = 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta     <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_data[i] <= 32'h0;
                r_err[i]  <= 1'b0;
            end
        end else begin
            r_inflight <= w_fire;
            if (w_fire) begin
                r_meta <= '{off:  w_off,
                            size: req_size_i,
                            uns:  req_unsigned_i,
                            we:   req_we_i,
                            err:  w_err};
            end
            if (w_push) begin
                r_data[r_wptr] <= w_fmt;
                r_err[r_wptr]  <= r_meta.err;
                r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign rsp_rdata_o = rsp_valid_o ? r_data[r_rptr] : 32'h0;
    assign rsp_err_o   = rsp_valid_o ? r_err[r_rptr]  : 1'b0;

endmodule
